// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, funct3 codes, register and decoded-instruction types for minon_cpu
package cpu_pkg;
   localparam logic [6:0]  OPC_NOP    = 7'b0000000;
   localparam logic [6:0]  OPC_OP     = 7'b1100110;
   localparam logic [6:0]  OPC_OPIMM  = 7'b1100100;
   localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

   localparam logic [2:0]  F3_ADD = 3'b000;
   localparam logic [2:0]  F3_SUB = 3'b001;
   localparam logic [2:0]  F3_AND = 3'b010;
   localparam logic [2:0]  F3_OR  = 3'b011;
   localparam logic [2:0]  F3_XOR = 3'b100;
   localparam logic [2:0]  F3_SLL = 3'b101;
   localparam logic [2:0]  F3_SRL = 3'b110;
   localparam logic [2:0]  F3_SRA = 3'b111;
   localparam logic [2:0]  F3_BEQ = 3'b000;
   localparam logic [2:0]  F3_BNE = 3'b001;

   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

   typedef struct packed {
      logic [31:0] data;
   } reg_t;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm_i;
      logic [7:0]  br_off;
   } dec_t;

   // Field order is reversed against RISC-V; the branch offset only needs the low 8 bits of imm12
   function automatic dec_t decode(input logic [31:0] w);
      dec_t d;
      d.opcode = w[31:25];
      d.rd     = w[24:20];
      d.funct3 = w[19:17];
      d.rs1    = w[16:12];
      d.rs2    = w[11:7];
      d.imm_i  = {{20{w[6]}}, w[6:0], w[11:7]};
      d.br_off = {w[2:0], w[24:20]};
      return d;
   endfunction
endpackage

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - combinational 32-bit ALU shared by OP and OP-IMM
module cpu_alu
   import cpu_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  funct3,
   output logic [31:0] y
);
   always_comb begin
      y = '0;
      case (funct3)
         F3_ADD: y = a + b;
         F3_SUB: y = a - b;
         F3_AND: y = a & b;
         F3_OR:  y = a | b;
         F3_XOR: y = a ^ b;
         F3_SLL: y = a << b[4:0];
         F3_SRL: y = a >> b[4:0];
         F3_SRA: y = $unsigned($signed(a) >>> b[4:0]);
         default: y = '0;
      endcase
   end
endmodule

// File: rtl/minon_cpu.sv
// rtl/minon_cpu.sv - single-cycle core: fetch, decode, register file, branch, PC, cycle counter, halt
module minon_cpu
   import cpu_pkg::*;
(
   input  logic CLOCK_50,
   input  logic RSTN_N
);
   logic [31:0] instCache [0:255];
   reg_t        regs      [0:31];
   logic [7:0]  pc;
   logic [31:0] clk_cnt;
   logic        is_halt_N;

   logic [31:0] inst;
   dec_t        dec;
   logic        is_halt_word;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [31:0] alu_b;
   logic [31:0] alu_y;
   logic        wr_en;
   logic        taken;
   logic [7:0]  pc_d;

   assign inst         = instCache[pc];
   assign dec          = decode(inst);
   assign is_halt_word = (inst == HALT_WORD);
   assign rs1_val      = (dec.rs1 == 5'd0) ? 32'd0 : regs[dec.rs1].data;
   assign rs2_val      = (dec.rs2 == 5'd0) ? 32'd0 : regs[dec.rs2].data;

   cpu_alu u_alu (
      .a      (rs1_val),
      .b      (alu_b),
      .funct3 (dec.funct3),
      .y      (alu_y)
   );

   always_comb begin
      wr_en = 1'b0;
      taken = 1'b0;
      alu_b = rs2_val;
      pc_d  = pc + 8'd1;
      if (!is_halt_N || is_halt_word) begin
         pc_d = pc;
      end else begin
         case (dec.opcode)
            OPC_OP: wr_en = 1'b1;
            OPC_OPIMM: begin
               wr_en = 1'b1;
               alu_b = dec.imm_i;
            end
            OPC_BRANCH: begin
               taken = ((dec.funct3 == F3_BEQ) && (rs1_val == rs2_val)) ||
                       ((dec.funct3 == F3_BNE) && (rs1_val != rs2_val));
            end
            OPC_NOP: wr_en = 1'b0;
            default: wr_en = 1'b0;
         endcase
         if (taken) pc_d = pc + dec.br_off;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (RSTN_N) begin
         pc        <= '0;
         clk_cnt   <= '0;
         is_halt_N <= 1'b1;
      end else if (is_halt_N) begin
         pc      <= pc_d;
         clk_cnt <= clk_cnt + 32'd1;
         if (is_halt_word) is_halt_N <= 1'b0;
      end
   end

   // Register contents survive reset; only the write is suppressed while reset is held
   always_ff @(posedge CLOCK_50) begin
      if (!RSTN_N && wr_en && (dec.rd != 5'd0)) regs[dec.rd].data <= alu_y;
   end
endmodule

// File: tb/tb_minon_cpu.sv
// tb/tb_minon_cpu.sv - scoreboard bench for minon_cpu against an ISA-level reference model
module tb_minon_cpu;
   localparam logic [6:0]  T_OP     = 7'b1100110;
   localparam logic [6:0]  T_OPIMM  = 7'b1100100;
   localparam logic [6:0]  T_BRANCH = 7'b1100011;
   localparam logic [31:0] T_HALT   = 32'hFFFF_FFFF;

   logic CLOCK_50 = 1'b0;
   logic RSTN_N   = 1'b1;

   minon_cpu dut (
      .CLOCK_50 (CLOCK_50),
      .RSTN_N   (RSTN_N)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   typedef struct packed {
      logic [7:0]        pc;
      logic [31:0]       cnt;
      logic              run;
      logic [31:0][31:0] regs;
   } snap_t;

   snap_t       exp_q[$];
   int          checks = 0;
   int          errors = 0;

   logic [31:0] m_mem  [0:255];
   logic [31:0] m_regs [0:31];
   logic [7:0]  m_pc;
   logic [31:0] m_cnt;
   logic        m_run;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [4:0] sh;
      sh = b[4:0];
      case (f)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return a << sh;
         3'd6: return a >> sh;
         default: return $unsigned($signed(a) >>> sh);
      endcase
   endfunction

   task automatic model_step(input logic rst);
      logic [31:0] w, a, b, imm, res;
      logic [4:0]  rd;
      if (rst) begin
         m_pc = 8'd0; m_cnt = 32'd0; m_run = 1'b1;
         return;
      end
      if (!m_run) return;
      m_cnt = m_cnt + 32'd1;
      w = m_mem[m_pc];
      if (w == T_HALT) begin
         m_run = 1'b0;
         return;
      end
      rd = w[24:20];
      a  = (w[16:12] == 5'd0) ? 32'd0 : m_regs[w[16:12]];
      b  = (w[11:7]  == 5'd0) ? 32'd0 : m_regs[w[11:7]];
      case (w[31:25])
         T_OP, T_OPIMM: begin
            imm = {{20{w[6]}}, w[6:0], w[11:7]};
            res = ref_alu(w[19:17], a, (w[31:25] == T_OP) ? b : imm);
            if (rd != 5'd0) m_regs[rd] = res;
            m_pc = m_pc + 8'd1;
         end
         T_BRANCH: begin
            imm = {{20{w[6]}}, w[6:0], w[24:20]};
            if ((w[19:17] == 3'd0 && a == b) || (w[19:17] == 3'd1 && a != b))
               m_pc = m_pc + imm[7:0];
            else
               m_pc = m_pc + 8'd1;
         end
         default: m_pc = m_pc + 8'd1;
      endcase
   endtask

   task automatic cycle(input logic rst);
      snap_t s;
      RSTN_N = rst;
      model_step(rst);
      s.pc  = m_pc;
      s.cnt = m_cnt;
      s.run = m_run;
      for (int r = 0; r < 32; r++) s.regs[r] = m_regs[r];
      exp_q.push_back(s);
      @(negedge CLOCK_50);
   endtask

   task automatic load_mem(input int idx, input logic [31:0] w);
      m_mem[idx] = w;
      dut.instCache[idx] = w;
   endtask

   task automatic load_reg(input int idx, input logic [31:0] v);
      m_regs[idx] = v;
      dut.regs[idx].data <= v;
   endtask

   task automatic clear_all();
      for (int i = 0; i < 256; i++) load_mem(i, 32'd0);
      for (int r = 0; r < 32; r++) load_reg(r, 32'd0);
   endtask

   function automatic logic [31:0] rand_inst();
      int          k;
      logic [31:0] w;
      k = $urandom_range(0, 39);
      w = $urandom;
      if (k == 39) return T_HALT;
      if (k < 14) begin
         w[31:25] = T_OP;
         w[24:20] = 5'($urandom_range(0, 7));
         w[11:7]  = 5'($urandom_range(0, 7));
      end else if (k < 24) begin
         w[31:25] = T_OPIMM;
         w[24:20] = 5'($urandom_range(0, 7));
      end else if (k < 32) begin
         w[31:25] = T_BRANCH;
         w[19:17] = 3'($urandom_range(0, 2));
         w[11:7]  = 5'($urandom_range(0, 3));
         w[6:0]   = {7{w[24]}};
      end else begin
         w[31:25] = 7'($urandom);
      end
      w[16:12] = 5'($urandom_range(0, 7));
      return w;
   endfunction

   // Monitor: every clock edge retires one architectural step; compare against the queued model state
   initial begin
      snap_t e;
      forever begin
         @(posedge CLOCK_50);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pc", {24'd0, dut.pc}, {24'd0, e.pc});
            check("clk_cnt", dut.clk_cnt, e.cnt);
            check("is_halt_N", {31'd0, dut.is_halt_N}, {31'd0, e.run});
            for (int r = 1; r < 8; r++)
               check($sformatf("regs[%0d]", r), dut.regs[r].data, e.regs[r]);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] add11, beq_back, bne_fwd, addi_r0, sub_r3, addi_r4;
      add11    = {T_OP,     5'd1, 3'b000, 5'd1, 5'd1, 7'd0};
      beq_back = {T_BRANCH, 5'b10110, 3'b000, 5'd1, 5'd1, 7'b1111111};
      bne_fwd  = {T_BRANCH, 5'd5, 3'b001, 5'd0, 5'd1, 7'd0};
      addi_r0  = {T_OPIMM,  5'd0, 3'b000, 5'd2, 5'd7, 7'd0};
      sub_r3   = {T_OP,     5'd3, 3'b001, 5'd1, 5'd2, 7'd0};
      addi_r4  = {T_OPIMM,  5'd4, 3'b000, 5'd0, 5'b10101, 7'b0000010};

      @(negedge CLOCK_50);

      // Doubling chain to HALT, then frozen
      clear_all();
      for (int i = 4; i <= 18; i++) load_mem(i, add11);
      load_mem(19, T_HALT);
      load_reg(1, 32'd1);
      cycle(1'b1);
      check("reset pc", {24'd0, dut.pc}, 32'd0);
      check("reset clk_cnt", dut.clk_cnt, 32'd0);
      check("reset is_halt_N", {31'd0, dut.is_halt_N}, 32'd1);
      repeat (20) cycle(1'b0);
      check("double r1", dut.regs[1].data, 32'd32768);
      check("double halted", {31'd0, dut.is_halt_N}, 32'd0);
      check("double pc", {24'd0, dut.pc}, 32'd19);
      check("double clk_cnt", dut.clk_cnt, 32'd20);
      repeat (50) cycle(1'b0);
      check("frozen r1", dut.regs[1].data, 32'd32768);
      check("frozen pc", {24'd0, dut.pc}, 32'd19);
      check("frozen clk_cnt", dut.clk_cnt, 32'd20);

      // Mid-run reset: leaves halt via reset, then interrupts the chain after six adds
      load_reg(1, 32'd1);
      cycle(1'b1);
      repeat (10) cycle(1'b0);
      cycle(1'b1);
      check("midrst pc", {24'd0, dut.pc}, 32'd0);
      check("midrst clk_cnt", dut.clk_cnt, 32'd0);
      check("midrst is_halt_N", {31'd0, dut.is_halt_N}, 32'd1);
      check("midrst r1 kept", dut.regs[1].data, 32'd64);
      repeat (20) cycle(1'b0);
      check("midrst r1 final", dut.regs[1].data, 32'h0020_0000);

      // Backward branch loop
      load_mem(19, beq_back);
      load_reg(1, 32'd1);
      cycle(1'b1);
      repeat (20) cycle(1'b0);
      check("branch pc", {24'd0, dut.pc}, 32'd9);
      repeat (10) cycle(1'b0);
      check("loop1 r1", dut.regs[1].data, 32'h0200_0000);
      repeat (11) cycle(1'b0);
      check("wrap r1", dut.regs[1].data, 32'd0);

      // bne not taken and x0 discard
      clear_all();
      load_mem(0, bne_fwd);
      load_mem(1, addi_r0);
      load_mem(2, sub_r3);
      load_mem(3, T_HALT);
      load_reg(2, 32'd5);
      cycle(1'b1);
      repeat (5) cycle(1'b0);
      check("sub r3", dut.regs[3].data, 32'hFFFF_FFFB);
      check("x0 kept", dut.regs[0].data, 32'd0);
      check("bne pc", {24'd0, dut.pc}, 32'd3);

      // PC wrap from 254 back to 0
      clear_all();
      load_mem(0, addi_r4);
      cycle(1'b1);
      m_pc = 8'd254;
      dut.pc <= 8'd254;
      repeat (2) cycle(1'b0);
      check("wrap pc", {24'd0, dut.pc}, 32'd0);
      cycle(1'b0);
      check("wrap exec r4", dut.regs[4].data, 32'h55);
      check("wrap pc+1", {24'd0, dut.pc}, 32'd1);

      // Random programs with occasional resets
      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < 256; i++) load_mem(i, rand_inst());
         for (int r = 0; r < 32; r++) load_reg(r, $urandom);
         cycle(1'b1);
         for (int c = 0; c < 250; c++) cycle($urandom_range(0, 59) == 0);
      end

      @(posedge CLOCK_50);
      #2;
      check("scoreboard drained", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/minon_cpu.md
# minon_cpu

Single-cycle 32-bit in-order processor core, the top of the design. Fetches one word per clock from an internal 256-word instruction store and executes a reduced field-reversed RISC-style ISA against a 32x32 register file. Stops on a halt word. Program and initial register values are preloaded hierarchically; reset does not clear them.

## Interface
- No parameters. Fixed: XLEN 32, IMEM_DEPTH 256 words, NREGS 32.
- CLOCK_50  in  1  sole clock, rising edge.
- RSTN_N  in  1  reset, synchronous and active-high despite the name: RSTN_N=1 at a rising edge resets.
- No other ports. Internal names are fixed for hierarchical preload and probing:
  - instCache[0:255] (32 b)
  - regs[0:31].data (32 b)
  - pc (8 b)
  - clk_cnt (32 b)
  - is_halt_N (1 b, 1 = running)

## Operation
- Encoding, MSB first:
  - [31:25] opcode
  - [24:20] rd / imm_lo
  - [19:17] funct3
  - [16:12] rs1
  - [11:7] rs2
  - [6:0] funct7 / imm_hi
- Immediates:
  - I-type imm12 = sext({[6:0],[11:7]}).
  - B-type imm12 = sext({[6:0],[24:20]}), in words, e.g. 1111111_10110 = -10.
- Opcodes:
  - 0000000 NOP.
  - 1100110 OP: rd = rs1 op rs2. funct3: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sll, 110 srl, 111 sra; shift amount rs2[4:0].
  - 1100100 OP-IMM: rd = rs1 op imm12, same funct3 map; shift amount imm[4:0].
  - 1100011 BRANCH: funct3 000 beq, 001 bne; taken when the condition holds.
  - 32'hFFFF_FFFF HALT. Checked on the whole word before opcode decode.
- Any other opcode executes as NOP; register file and PC advance are unaffected.
- Arithmetic is modulo 2^32; overflow wraps silently.
- regs[0] reads as 0 and writes to it are discarded.
- Register reads are combinational from the pre-edge state. Writeback occurs at the same edge, so back-to-back dependent instructions see fresh values.
- Next PC:
  - Taken branch: pc + imm12, truncated to 8 b (wraps mod 256).
  - Otherwise: pc + 1, with 255 wrapping to 0.
- HALT at the edge it executes:
  - is_halt_N <= 0, pc holds.
  - No register writes from then on; state is frozen until reset.

## Timing
- One instruction per cycle; effects visible after the rising edge that executes it.
- Reset (RSTN_N=1 at an edge):
  - pc <= 0, clk_cnt <= 0, is_halt_N <= 1.
  - regs and instCache untouched.
  - Reset wins over any instruction in that cycle, including mid-program or while halted.
- clk_cnt increments by 1 at every non-reset edge where is_halt_N=1 before the edge, including the edge executing HALT. It then holds and wraps at 2^32.
- Halt-to-run exit is only through reset.

## Structure
- Package cpu_pkg:
  - opcode and funct3 localparams, HALT_WORD.
  - reg_t struct { logic [31:0] data; }, used for regs.
  - decoded-instruction struct.
- Sub-module cpu_alu: 32-bit combinational, inputs a, b, funct3; output y. Shared by OP and OP-IMM.
- Top CPU holds fetch, decode, branch compare, register file, PC, counter and halt flag.

## Test plan
- Doubling chain:
  - Preload regs[1]=1; instCache[0..3]=0; instCache[4..18] = add r1,r1,r1 (32'b1100110_00001_000_00001_00001_0000000); instCache[19]=HALT.
  - Pulse reset one cycle, release.
  - Required: regs[1]=32768, is_halt_N=0, pc=19, clk_cnt=20, unchanged 50 cycles later.
- Backward branch:
  - Same program, but instCache[19] = beq r1,r1,-10 (32'b1100011_10110_000_00001_00001_1111111).
  - Required: pc=9 the cycle after the branch.
  - Required: regs[1]=2^25 after the first loop pass (after 10 more adds).
  - Required: regs[1]=0 once 2^32 wraps.
- bne not taken and x0:
  - Preload regs[1]=0, regs[2]=5. Execute: bne r0,r1 (falls through); OP-IMM add r0,r2,7 (regs[0] stays 0); sub r3,r1,r2.
  - Required: regs[3]=0xFFFF_FFFB.
- PC wrap: NOPs at 254 and 255 with pc forced near 254 -> pc reaches 0 and executes instCache[0].
- Mid-run reset: assert RSTN_N during the doubling loop -> next edge pc=0, clk_cnt=0, is_halt_N=1, regs[1] keeps its pre-reset value.
